// File: rtl/ex_mult_iter.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mult_iter
//  Purpose  : Iterative shift-add multiplier for the EX stage. Retires one
//             multiplier bit per cycle, stalls the front of the pipeline
//             while running, and hands a registered low-half product plus
//             destination register to the EX_MEM register.
//  Ports    : clk     - rising-edge clock
//             arst_n  - asynchronous active-low reset
//             start   - EX holds a MUL instruction
//             flush   - squash any in-flight operation
//             op_a    - multiplicand (DATA_W)
//             op_b    - multiplier   (DATA_W)
//             rd_in   - destination register of the MUL (RD_W)
//             busy    - stall request to hazard logic
//             valid   - one-cycle pulse, completed op ready for EX_MEM
//             result  - product[DATA_W-1:0], held until the next completion
//             rd_out  - destination register of the completed op, held
//  Revision : 1.0 - initial release
// ============================================================================
module ex_mult_iter #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              flush,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [RD_W-1:0]   rd_in,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] result,
    output logic [RD_W-1:0]   rd_out
);

    localparam int                C_CNT_W    = $clog2(DATA_W);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_a_sh;
    logic [DATA_W-1:0]   r_b_sh;
    logic [RD_W-1:0]     r_rd_q;
    logic [DATA_W-1:0]   r_result;
    logic [RD_W-1:0]     r_rd_out;
    logic                w_launch;
    logic                w_step;
    logic                w_commit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. busy drops in DONE so ID_EX can advance on
    // the same edge that commits the result; a start seen in DONE is the
    // same MUL leaving ID_EX and must not relaunch.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        valid        = 1'b0;
        w_launch     = 1'b0;
        w_step       = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !flush) begin
                    w_launch     = 1'b1;
                    busy         = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    w_state_next = ST_IDLE;
                end else begin
                    busy   = 1'b1;
                    w_step = 1'b1;
                    if (r_cnt == C_CNT_LAST) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                valid        = !flush;
                w_commit     = !flush;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. Operands are captured only at launch, so later changes on
    // the ID_EX outputs cannot disturb the running product.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_rd_q   <= '0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            if (w_launch) begin
                r_a_sh <= op_a;
                r_b_sh <= op_b;
                r_rd_q <= rd_in;
                r_acc  <= '0;
                r_cnt  <= '0;
            end else if (w_step) begin
                // Carries beyond DATA_W fall off: only the low half is kept.
                r_acc  <= r_acc + (r_b_sh[0] ? r_a_sh : '0);
                r_a_sh <= r_a_sh << 1;
                r_b_sh <= r_b_sh >> 1;
                r_cnt  <= r_cnt + C_CNT_W'(1);
            end
            if (w_commit) begin
                r_result <= r_acc;
                r_rd_out <= r_rd_q;
            end
        end
    end

    assign result = r_result;
    assign rd_out = r_rd_out;

endmodule
`default_nettype wire
